// File: rtl/eq_coeff_loader_if.sv
// eq_coeff_loader_if: band-gain writes, sweep control and equalizer coefficient write port
interface eq_coeff_loader_if #(
  parameter int SAMPLES    = 2048,
  parameter int BANDS      = 16,
  parameter int COEFF_BITS = 8
);
  logic                       band_valid;
  logic                       band_ready;
  logic [$clog2(BANDS)-1:0]   band_idx;
  logic [COEFF_BITS-1:0]      band_gain;
  logic                       start;
  logic                       busy;
  logic                       done;
  logic                       coeff_wr_en;
  logic [$clog2(SAMPLES)-1:0] coeff_index;
  logic [COEFF_BITS-1:0]      coeff_in;
  modport master (
    output band_valid, band_idx, band_gain, start,
    input  band_ready, busy, done, coeff_wr_en, coeff_index, coeff_in
  );
  modport slave (
    input  band_valid, band_idx, band_gain, start,
    output band_ready, busy, done, coeff_wr_en, coeff_index, coeff_in
  );
endinterface

// File: rtl/eq_coeff_loader.sv
// eq_coeff_loader: mirrored per-bin gain sweep into the equalizer; EQ_LOADER_INTERP_EN enables linear band interpolation
module eq_coeff_loader #(
  parameter int SAMPLES             = 2048,
  parameter int BANDS               = 16,
  parameter int COEFF_BITS          = 8,
  parameter int COEFF_FRACTION_BITS = 5
) (
  input logic clk,
  input logic rst_n,
  eq_coeff_loader_if.slave bus
);
  localparam int IW = $clog2(SAMPLES);
  localparam int BW = $clog2(BANDS);
  localparam int H  = SAMPLES / 2;
  localparam int W  = H / BANDS;
  localparam int WW = $clog2(W);
  localparam logic [COEFF_BITS-1:0] UNITY = COEFF_BITS'(1 << COEFF_FRACTION_BITS);
  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI, DONE} state_t;
  state_t state;
  logic [IW-1:0] k, kv, idx_n;
  logic [COEFF_BITS-1:0] g [BANDS];
  logic [COEFF_BITS-1:0] gf [BANDS];
  logic [COEFF_BITS-1:0] g_lo, val;
  logic [BW-1:0] b;
  logic wr_acc, go, wr_n;
  assign wr_acc = bus.band_valid && bus.band_ready;
  assign go     = state == IDLE && bus.start;
  assign kv     = state == IDLE ? '0 : state == WR_HI ? k + IW'(1) : k == '0 ? IW'(1) : k;
  assign b      = kv >= IW'(H) ? BW'(BANDS - 1) : kv[WW+BW-1:WW];
  assign wr_n   = go || state == WR_HI || (state == WR_LO && k != IW'(H));
  assign idx_n  = (state == WR_LO && k != '0) ? '0 - k : kv;
  // bypass a gain write landing in the same cycle as start so bin 0 already sees it
  always_comb
    for (int i = 0; i < BANDS; i++)
      gf[i] = (wr_acc && bus.band_idx == BW'(i)) ? bus.band_gain : g[i];
  assign g_lo = gf[b];
`ifdef EQ_LOADER_INTERP_EN
  localparam int PW = COEFF_BITS + 1 + WW;
  logic signed [PW-1:0] gd, jx;
  assign gd  = $signed(PW'(gf[b + BW'(1)])) - $signed(PW'(g_lo));
  assign jx  = $signed(PW'(kv[WW-1:0]));
  assign val = b == BW'(BANDS - 1) ? g_lo
             : COEFF_BITS'($signed(PW'(g_lo)) + ((gd * jx) >>> WW));
`else
  assign val = g_lo;
`endif
  // sweep FSM with gain file and registered equalizer-facing outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state           <= IDLE;
      k               <= '0;
      for (int i = 0; i < BANDS; i++) g[i] <= UNITY;
      bus.band_ready  <= 1'b1;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.coeff_wr_en <= 1'b0;
      bus.coeff_index <= '0;
      bus.coeff_in    <= '0;
    end else begin
      if (wr_acc) g[bus.band_idx] <= bus.band_gain;
      bus.coeff_wr_en <= wr_n;
      bus.coeff_index <= wr_n ? idx_n : '0;
      bus.coeff_in    <= wr_n ? val : '0;
      bus.done        <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state          <= WR_LO;
          k              <= kv;
          bus.busy       <= 1'b1;
          bus.band_ready <= 1'b0;
        end
        WR_LO: begin
          state    <= k == IW'(H) ? DONE : k == '0 ? WR_LO : WR_HI;
          k        <= kv;
          bus.done <= k == IW'(H);
        end
        WR_HI: begin
          state <= WR_LO;
          k     <= kv;
        end
        default: begin
          state          <= IDLE;
          bus.busy       <= 1'b0;
          bus.band_ready <= 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_eq_coeff_loader.sv
// tb_eq_coeff_loader: directed checks of sweep order, timing, gain values, busy guards and async reset
module tb_eq_coeff_loader;
  localparam int SAMPLES = 2048;
  localparam int BANDS = 16;
  localparam int COEFF_BITS = 8;
`ifdef EQ_LOADER_INTERP_EN
  localparam bit INTERP = 1'b1;
`else
  localparam bit INTERP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [COEFF_BITS-1:0] vals [SAMPLES];
  eq_coeff_loader_if #(.SAMPLES(SAMPLES), .BANDS(BANDS), .COEFF_BITS(COEFF_BITS)) bus ();
  eq_coeff_loader #(.SAMPLES(SAMPLES), .BANDS(BANDS), .COEFF_BITS(COEFF_BITS), .COEFF_FRACTION_BITS(5)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int exp_idx(input int p);
    int m = (p + 1) / 2;
    return p == 0 ? 0 : p == SAMPLES - 1 ? SAMPLES / 2 : (p % 2 == 1) ? m : SAMPLES - m;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic band_write(input int i, input int g);
    bus.band_valid = 1'b1;
    bus.band_idx = 4'(i);
    bus.band_gain = 8'(g);
    tick();
    bus.band_valid = 1'b0;
  endtask
  task automatic cb(input int bin, input int e_step, input int e_interp);
    check($sformatf("bin%0d", bin), 32'(vals[bin]), INTERP ? e_interp : e_step);
  endtask
  task automatic sweep(input string tag, input bit abuse, input bit wv, input int wi, input int wg);
    int n_wr = 0, bad_idx = 0, gaps = 0, busy_bad = 0, done_bad = 0, rdy_bad = 0;
    bit seen [SAMPLES];
    foreach (seen[i]) seen[i] = 1'b0;
    bus.start = 1'b1;
    if (wv) begin
      bus.band_valid = 1'b1;
      bus.band_idx = 4'(wi);
      bus.band_gain = 8'(wg);
    end
    tick();
    bus.start = 1'b0;
    bus.band_valid = 1'b0;
    for (int c = 1; c <= SAMPLES + 2; c++) begin
      if (bus.coeff_wr_en === 1'b1) begin
        if (n_wr >= SAMPLES || int'(bus.coeff_index) != exp_idx(n_wr) || seen[bus.coeff_index]) bad_idx++;
        seen[bus.coeff_index] = 1'b1;
        vals[bus.coeff_index] = bus.coeff_in;
        n_wr++;
      end else if (c <= SAMPLES) gaps++;
      if (bus.busy !== (c <= SAMPLES + 1)) busy_bad++;
      if (bus.done !== (c == SAMPLES + 1)) done_bad++;
      if (bus.band_ready !== (c == SAMPLES + 2)) rdy_bad++;
      if (abuse && c == 100) begin
        check({tag, "_ready_while_busy"}, 32'(bus.band_ready), 0);
        bus.start = 1'b1;
        bus.band_valid = 1'b1;
        bus.band_idx = 4'd3;
        bus.band_gain = 8'd0;
      end
      tick();
      if (abuse && c == 100) begin
        bus.start = 1'b0;
        bus.band_valid = 1'b0;
      end
    end
    check({tag, "_wr_count"}, n_wr, SAMPLES);
    check({tag, "_idx_seq"}, bad_idx, 0);
    check({tag, "_wr_gaps"}, gaps, 0);
    check({tag, "_busy"}, busy_bad, 0);
    check({tag, "_done"}, done_bad, 0);
    check({tag, "_ready"}, rdy_bad, 0);
  endtask
  task automatic check_all_unity(input string tag);
    int n = 0;
    foreach (vals[i]) if (vals[i] !== 8'd32) n++;
    check(tag, n, 0);
  endtask
  initial begin
    int n, dn;
    bus.band_valid = 1'b0;
    bus.band_idx = '0;
    bus.band_gain = '0;
    bus.start = 1'b0;
    repeat (3) tick();
    check("rst_wr_en", 32'(bus.coeff_wr_en), 0);
    check("rst_index", 32'(bus.coeff_index), 0);
    check("rst_coeff", 32'(bus.coeff_in), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_ready", 32'(bus.band_ready), 1);
    rst_n = 1'b1;
    tick();
    sweep("unity", 1'b0, 1'b0, 0, 0);
    check_all_unity("unity_vals");
    band_write(0, 64);
    band_write(1, 0);
    sweep("g01", 1'b0, 1'b0, 0, 0);
    cb(0, 64, 64);
    cb(1, 64, 63);
    cb(32, 64, 32);
    cb(63, 64, 1);
    cb(64, 0, 0);
    cb(127, 0, 31);
    cb(128, 32, 32);
    cb(1984, 0, 0);
    cb(1985, 64, 1);
    cb(2047, 64, 63);
    band_write(14, 32);
    sweep("g15", 1'b0, 1'b1, 15, 255);
    cb(896, 32, 32);
    cb(959, 32, 251);
    cb(960, 255, 255);
    cb(1023, 255, 255);
    cb(1024, 255, 255);
    cb(1025, 255, 255);
    sweep("abuse", 1'b1, 1'b0, 0, 0);
    cb(200, 32, 32);
    cb(255, 32, 32);
    cb(0, 64, 64);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    dn = 0;
    for (int c = 0; c < 600 && n < 500; c++) begin
      if (bus.coeff_wr_en === 1'b1) n++;
      if (bus.done === 1'b1) dn++;
      if (n < 500) tick();
    end
    check("pre_rst_writes", n, 500);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_wr_en", 32'(bus.coeff_wr_en), 0);
    check("midrst_index", 32'(bus.coeff_index), 0);
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_ready", 32'(bus.band_ready), 1);
    repeat (2) begin
      tick();
      if (bus.done === 1'b1) dn++;
    end
    rst_n = 1'b1;
    tick();
    if (bus.done === 1'b1) dn++;
    check("midrst_no_done", dn, 0);
    sweep("post_rst", 1'b0, 1'b0, 0, 0);
    check_all_unity("post_rst_vals");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
